// File: rtl/sample_rate_streamer.sv
// Turns rising edges of the slow rate clock into single-cycle ticks in the inclk domain
// and pops one buffered sample per tick onto a held output register.
module sample_rate_streamer #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int UFLOW_WIDTH = 16
) (
    input  logic                   inclk,
    input  logic                   reset,
    input  logic                   rate_clk,
    input  logic                   enable,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   clear_underflow,
    output logic [DATA_WIDTH-1:0]  sample_out,
    output logic                   sample_strobe,
    output logic                   underflow,
    output logic [UFLOW_WIDTH-1:0] underflow_count,
    output logic [ADDR_WIDTH:0]    fill_level
);

    localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];

    logic                   s1_q, s2_q, s3_q;
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic [DATA_WIDTH-1:0]  out_q, out_d;
    logic                   strobe_q, strobe_d;
    logic                   uflag_q, uflag_d;
    logic [UFLOW_WIDTH-1:0] ucnt_q, ucnt_d;

    logic tick, rd_tick, wr_en, rd_en, uf_ev;

    // s1 is the metastability catcher; s2/s3 form the edge detector
    assign tick     = s2_q & ~s3_q;
    assign in_ready = (count_q != FULL_LVL);
    assign rd_tick  = tick & enable;
    assign wr_en    = in_valid & in_ready;
    assign rd_en    = rd_tick & (count_q != '0);
    assign uf_ev    = rd_tick & (count_q == '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        strobe_d = rd_tick;
        uflag_d  = uflag_q;
        ucnt_d   = ucnt_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            out_d    = mem[rd_ptr_q];
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clear has priority over an underflow landing on the same edge
        if (clear_underflow) begin
            uflag_d = 1'b0;
            ucnt_d  = '0;
        end else if (uf_ev) begin
            uflag_d = 1'b1;
            if (!(&ucnt_q)) begin
                ucnt_d = ucnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            strobe_q <= 1'b0;
            uflag_q  <= 1'b0;
            ucnt_q   <= '0;
        end else begin
            s1_q     <= rate_clk;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            strobe_q <= strobe_d;
            uflag_q  <= uflag_d;
            ucnt_q   <= ucnt_d;
        end
    end

    // Sample storage carries no reset; stale contents are unreachable once pointers clear
    always_ff @(posedge inclk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    assign sample_out      = out_q;
    assign sample_strobe   = strobe_q;
    assign underflow       = uflag_q;
    assign underflow_count = ucnt_q;
    assign fill_level      = count_q;

endmodule

// File: tb/tb_sample_rate_streamer.sv
// Bench for sample_rate_streamer: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model.
module tb_sample_rate_streamer;

    logic        inclk = 1'b0;
    logic        reset;
    logic        rate_clk;
    logic        enable;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        clear_underflow;
    logic [7:0]  sample_out;
    logic        sample_strobe;
    logic        underflow;
    logic [15:0] underflow_count;
    logic [4:0]  fill_level;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    sample_rate_streamer dut (
        .inclk           (inclk),
        .reset           (reset),
        .rate_clk        (rate_clk),
        .enable          (enable),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .clear_underflow (clear_underflow),
        .sample_out      (sample_out),
        .sample_strobe   (sample_strobe),
        .underflow       (underflow),
        .underflow_count (underflow_count),
        .fill_level      (fill_level)
    );

    // clock / reset
    always #5 inclk = ~inclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // reference model: FIFO as a queue, ticks scheduled two edges after a sampled rise
    logic [7:0] exp_q[$];
    int         tick_due[$];
    int         m_edge;
    bit         m_prev;
    logic [7:0] m_out;
    bit         m_strobe;
    bit         m_uf;
    int         m_ucnt;

    task automatic model_reset();
        exp_q.delete();
        tick_due.delete();
        m_edge   = 0;
        m_prev   = 1'b0;
        m_out    = 8'h00;
        m_strobe = 1'b0;
        m_uf     = 1'b0;
        m_ucnt   = 0;
    endtask

    always @(posedge inclk or posedge reset) begin
        bit tk, rd, wr, uf_now;
        if (reset) begin
            model_reset();
        end else begin
            m_edge++;
            tk = 1'b0;
            if (tick_due.size() > 0 && tick_due[0] == m_edge) begin
                tk = 1'b1;
                void'(tick_due.pop_front());
            end
            if (rate_clk && !m_prev) tick_due.push_back(m_edge + 2);
            m_prev = rate_clk;

            rd     = tk && enable;
            wr     = in_valid && (exp_q.size() < 16);
            uf_now = 1'b0;
            m_strobe = rd;
            if (rd) begin
                if (exp_q.size() > 0) m_out = exp_q.pop_front();
                else uf_now = 1'b1;
            end
            if (clear_underflow) begin
                m_uf   = 1'b0;
                m_ucnt = 0;
            end else if (uf_now) begin
                m_uf = 1'b1;
                if (m_ucnt < 65535) m_ucnt++;
            end
            if (wr) exp_q.push_back(in_data);
        end
    end

    // scoreboard: compare every cycle on the falling edge
    always @(negedge inclk) begin
        if (chk_on) begin
            chk("sample_out", 32'(sample_out), 32'(m_out));
            chk("sample_strobe", 32'(sample_strobe), 32'(m_strobe));
            chk("underflow", 32'(underflow), 32'(m_uf));
            chk("underflow_count", 32'(underflow_count), 32'(m_ucnt));
            chk("fill_level", 32'(fill_level), 32'(exp_q.size()));
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() != 16));
        end
    end

    // driver tasks (called right after a falling edge)
    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge inclk);
        in_valid = 1'b0;
    endtask

    task automatic pulse(input int hi, input int lo, input bit exp_strobe);
        rate_clk = 1'b1;
        for (int i = 1; i <= hi + lo; i++) begin
            if (i == hi + 1) rate_clk = 1'b0;
            @(negedge inclk);
            if (i <= 4) chk("strobe_latency", 32'(sample_strobe), 32'((i == 3) ? exp_strobe : 1'b0));
        end
    endtask

    initial begin
        reset = 1'b1; rate_clk = 1'b0; enable = 1'b1; in_data = 8'h00;
        in_valid = 1'b0; clear_underflow = 1'b0;
        model_reset();
        @(negedge inclk);
        chk_on = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_fill", 32'(fill_level), 32'd0);
        repeat (2) @(negedge inclk);
        reset = 1'b0;
        @(negedge inclk);

        // four samples drained by four slow-clock pulses
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        pulse(10, 10, 1'b1); chk("t1_out0", 32'(sample_out), 32'h11);
        pulse(10, 10, 1'b1); chk("t1_out1", 32'(sample_out), 32'h22);
        pulse(10, 10, 1'b1); chk("t1_out2", 32'(sample_out), 32'h33);
        pulse(10, 10, 1'b1); chk("t1_out3", 32'(sample_out), 32'h44);
        chk("t1_fill", 32'(fill_level), 32'd0);

        // underflow on an empty FIFO, then clear
        repeat (3) pulse(4, 4, 1'b1);
        chk("uf_hold", 32'(sample_out), 32'h44);
        chk("uf_flag", 32'(underflow), 32'd1);
        chk("uf_count", 32'(underflow_count), 32'd3);
        clear_underflow = 1'b1;
        @(negedge inclk);
        clear_underflow = 1'b0;
        chk("uf_clr_flag", 32'(underflow), 32'd0);
        chk("uf_clr_count", 32'(underflow_count), 32'd0);

        // write landing on the same edge as a tick on an empty FIFO
        rate_clk = 1'b1;
        repeat (2) @(negedge inclk);
        in_valid = 1'b1; in_data = 8'h5A;
        @(negedge inclk);
        in_valid = 1'b0;
        chk("coinc_count", 32'(underflow_count), 32'd1);
        chk("coinc_fill", 32'(fill_level), 32'd1);
        repeat (2) @(negedge inclk);
        rate_clk = 1'b0;
        repeat (4) @(negedge inclk);
        pulse(4, 4, 1'b1);
        chk("coinc_out", 32'(sample_out), 32'h5A);

        // ticks ignored while disabled
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
        enable = 1'b0;
        repeat (4) pulse(4, 4, 1'b0);
        chk("dis_fill", 32'(fill_level), 32'd5);
        enable = 1'b1;
        pulse(4, 4, 1'b1);
        chk("dis_out", 32'(sample_out), 32'hC0);
        repeat (4) pulse(3, 3, 1'b1);

        // full FIFO back-pressure
        for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
        in_valid = 1'b1; in_data = 8'hAA;
        repeat (3) @(negedge inclk);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_fill", 32'(fill_level), 32'd16);
        rate_clk = 1'b1;
        repeat (3) @(negedge inclk);
        chk("full_pop_fill", 32'(fill_level), 32'd15);
        chk("full_pop_ready", 32'(in_ready), 32'd1);
        @(negedge inclk);
        in_valid = 1'b0;
        chk("full_refill", 32'(fill_level), 32'd16);
        rate_clk = 1'b0;
        repeat (4) @(negedge inclk);
        repeat (16) pulse(3, 3, 1'b1);
        chk("full_last", 32'(sample_out), 32'hAA);

        // asynchronous reset mid-operation
        pulse(3, 3, 1'b1);
        for (int i = 0; i < 7; i++) push(8'(8'h70 + i));
        chk("pre_rst_fill", 32'(fill_level), 32'd7);
        chk("pre_rst_uf", 32'(underflow), 32'd1);
        @(posedge inclk);
        #3 reset = 1'b1;
        #1;
        chk("arst_out", 32'(sample_out), 32'd0);
        chk("arst_strobe", 32'(sample_strobe), 32'd0);
        chk("arst_uf", 32'(underflow), 32'd0);
        chk("arst_count", 32'(underflow_count), 32'd0);
        chk("arst_fill", 32'(fill_level), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        @(negedge inclk);
        @(negedge inclk);
        reset = 1'b0;
        @(negedge inclk);
        push(8'h11); push(8'h22);
        pulse(5, 5, 1'b1); chk("post_rst_out0", 32'(sample_out), 32'h11);
        pulse(5, 5, 1'b1); chk("post_rst_out1", 32'(sample_out), 32'h22);
        chk("post_rst_fill", 32'(fill_level), 32'd0);

        // random traffic against the model
        begin
            int phase_left = 3;
            for (int c = 0; c < 4000; c++) begin
                in_valid        = ($urandom_range(0, 99) < 35);
                in_data         = 8'($urandom_range(0, 255));
                clear_underflow = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 199) == 0) enable = ~enable;
                phase_left--;
                if (phase_left == 0) begin
                    rate_clk   = ~rate_clk;
                    phase_left = $urandom_range(2, 6);
                end
                @(negedge inclk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
